// File: rtl/packet_arbiter_pkg.sv
// packet_arbiter_pkg: shared widths, arbiter state encodings and channel indices
package packet_arbiter_pkg;
  localparam int PKT_HEAD_WIDTH = 16;
  localparam int PKT_DATA_WIDTH = 32;
  typedef enum logic [1:0] {ARB_IDLE_s = 2'd0, ARB_CH0_s = 2'd1, ARB_CH1_s = 2'd2} arb_state_e;
  localparam logic CH_REQ = 1'b0;
  localparam logic CH_ACK = 1'b1;
endpackage

// File: rtl/packet_arbiter_if.sv
// packet_arbiter_if: packet beat bus (valid/ready with head, data, start, last)
// master drives the beat and samples ready; slave receives the beat and drives ready
interface packet_arbiter_if import packet_arbiter_pkg::*; #(
  parameter int HW = PKT_HEAD_WIDTH,
  parameter int DW = PKT_DATA_WIDTH
);
  logic          valid;
  logic [HW-1:0] head;
  logic [DW-1:0] data;
  logic          start;
  logic          last;
  logic          ready;
  modport master(output valid, head, data, start, last, input ready);
  modport slave(input valid, head, data, start, last, output ready);
endinterface

// File: rtl/packet_egress_reg.sv
// packet_egress_reg: registered valid/ready output stage for packet beats
// clk, rst_n: clock and async active-low reset
// load_i, head_i, data_i, start_i, last_i: beat to capture this cycle
// free_o: stage can take a beat this cycle; send_o: registered egress bus
module packet_egress_reg import packet_arbiter_pkg::*; #(
  parameter int HW = PKT_HEAD_WIDTH,
  parameter int DW = PKT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic [HW-1:0]            head_i,
  input  logic [DW-1:0]            data_i,
  input  logic                     start_i,
  input  logic                     last_i,
  output logic                     free_o,
  packet_arbiter_if.master         send_o
);
  logic          valid_q;
  logic [HW-1:0] head_q;
  logic [DW-1:0] data_q;
  logic          start_q;
  logic          last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      head_q  <= head_i;
      data_q  <= data_i;
      start_q <= start_i;
      last_q  <= last_i;
    end else if (send_o.ready)
      valid_q <= 1'b0;
  assign free_o       = !valid_q || send_o.ready;
  assign send_o.valid = valid_q;
  assign send_o.head  = head_q;
  assign send_o.data  = data_q;
  assign send_o.start = start_q;
  assign send_o.last  = last_q;
endmodule

// File: rtl/packet_arbiter.sv
// packet_arbiter: packet-atomic 2-channel round-robin merge with optional ACK priority
// clk, rst_n: clock and async active-low reset
// ch0_i: request/response stream; ch1_i: ACKNOWLEDGE stream; send_o: registered egress
// ov_channel_0_pkt_cnt / ov_channel_1_pkt_cnt: packets forwarded per channel
module packet_arbiter import packet_arbiter_pkg::*; #(
  parameter int HEAD_WIDTH   = PKT_HEAD_WIDTH,
  parameter int DATA_WIDTH   = PKT_DATA_WIDTH,
  parameter bit ACK_PRIORITY = 1'b0,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  packet_arbiter_if.slave      ch0_i,
  packet_arbiter_if.slave      ch1_i,
  packet_arbiter_if.master     send_o,
  output logic [CNT_WIDTH-1:0] ov_channel_0_pkt_cnt,
  output logic [CNT_WIDTH-1:0] ov_channel_1_pkt_cnt
);
  arb_state_e           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;
  logic                 free, rdy0, rdy1, acc0, acc1, req0, req1, grant1, done;
  assign req0 = ch0_i.valid && ch0_i.start;
  assign req1 = ch1_i.valid && ch1_i.start;
  assign acc0 = ch0_i.valid && rdy0;
  assign acc1 = ch1_i.valid && rdy1;
  assign done = (acc0 && ch0_i.last) || (acc1 && ch1_i.last);
  // channel 1 takes an idle-time conflict under ACK priority or when channel 0 had the last grant
  assign grant1 = req1 && (!req0 || ACK_PRIORITY || last_grant_q == CH_REQ);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= ARB_IDLE_s;
      last_grant_q <= CH_ACK;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  always_comb begin
    state_d      = state_q == ARB_IDLE_s ? (grant1 ? ARB_CH1_s : req0 ? ARB_CH0_s : ARB_IDLE_s)
                                         : (done ? ARB_IDLE_s : state_q);
    last_grant_d = (state_q == ARB_IDLE_s && (req0 || req1)) ? grant1 : last_grant_q;
  end
  always_comb begin
    rdy0 = state_q == ARB_CH0_s && free;
    rdy1 = state_q == ARB_CH1_s && free;
  end
  assign ch0_i.ready = rdy0;
  assign ch1_i.ready = rdy1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc0 && ch0_i.last) cnt0_q <= cnt0_q + 1'b1;
      if (acc1 && ch1_i.last) cnt1_q <= cnt1_q + 1'b1;
    end
  assign ov_channel_0_pkt_cnt = cnt0_q;
  assign ov_channel_1_pkt_cnt = cnt1_q;
  packet_egress_reg #(.HW(HEAD_WIDTH), .DW(DATA_WIDTH)) u_egress (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (acc0 || acc1),
    .head_i  (acc1 ? ch1_i.head : ch0_i.head),
    .data_i  (acc1 ? ch1_i.data : ch0_i.data),
    .start_i (acc1 ? ch1_i.start : ch0_i.start),
    .last_i  (acc1 ? ch1_i.last : ch0_i.last),
    .free_o  (free),
    .send_o  (send_o)
  );
endmodule

// File: tb/tb_packet_arbiter.sv
// tb_packet_arbiter: directed vector table plus reset and ACK-priority sequences
module tb_packet_arbiter;
  import packet_arbiter_pkg::*;
  typedef struct {
    logic [2:0]  in0;
    logic [31:0] d0;
    logic [2:0]  in1;
    logic [31:0] d1;
    logic        sr;
    logic [2:0]  rv;
    logic [31:0] od;
    logic [1:0]  sl;
    logic [31:0] c0;
    logic [31:0] c1;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cnt0, cnt1;
  logic [1:0]  pcnt0, pcnt1;
  int          n = 0;
  int          errs = 0;
  vec_t        q[$];
  packet_arbiter_if c0_if();
  packet_arbiter_if c1_if();
  packet_arbiter_if tx_if();
  packet_arbiter_if p0_if();
  packet_arbiter_if p1_if();
  packet_arbiter_if ptx_if();
  always #5 clk = ~clk;
  packet_arbiter dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ch0_i                (c0_if),
    .ch1_i                (c1_if),
    .send_o               (tx_if),
    .ov_channel_0_pkt_cnt (cnt0),
    .ov_channel_1_pkt_cnt (cnt1)
  );
  packet_arbiter #(.ACK_PRIORITY(1'b1), .CNT_WIDTH(2)) dut_p (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ch0_i                (p0_if),
    .ch1_i                (p1_if),
    .send_o               (ptx_if),
    .ov_channel_0_pkt_cnt (pcnt0),
    .ov_channel_1_pkt_cnt (pcnt1)
  );
  function automatic vec_t V(input logic [2:0] in0, input logic [31:0] d0, input logic [2:0] in1,
                             input logic [31:0] d1, input logic sr, input logic [2:0] rv,
                             input logic [31:0] od, input logic [1:0] sl, input logic [31:0] c0,
                             input logic [31:0] c1);
    vec_t v;
    v.in0 = in0; v.d0 = d0; v.in1 = in1; v.d1 = d1; v.sr = sr;
    v.rv = rv; v.od = od; v.sl = sl; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction
  function automatic logic [15:0] hd(input logic [31:0] d);
    return d[15:0] ^ 16'h5A5A;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] in0, input logic [31:0] d0, input logic [2:0] in1,
                       input logic [31:0] d1, input logic sr);
    {c0_if.valid, c0_if.start, c0_if.last} = in0;
    c0_if.data = d0;
    c0_if.head = hd(d0);
    {c1_if.valid, c1_if.start, c1_if.last} = in1;
    c1_if.data = d1;
    c1_if.head = hd(d1);
    tx_if.ready = sr;
  endtask
  initial begin
    int seen;
    drive(3'b000, 0, 3'b000, 0, 1'b1);
    {p0_if.valid, p0_if.start, p0_if.last, p0_if.head, p0_if.data} = '0;
    {p1_if.valid, p1_if.start, p1_if.last, p1_if.head, p1_if.data} = '0;
    ptx_if.ready = 1'b1;
    #12;
    chk("rst ov", tx_if.valid, 0);
    chk("rst r0", c0_if.ready, 0);
    chk("rst cnt", cnt0 | cnt1, 0);
    chk("rst p ov", ptx_if.valid, 0);
    @(negedge clk) rst_n = 1'b1;
    q.push_back(V(3'b111, 'hB1, 3'b111, 'hC1, 1, 3'b000, 0,     2'b00, 0, 0));
    q.push_back(V(3'b111, 'hB1, 3'b111, 'hC1, 1, 3'b100, 0,     2'b00, 0, 0));
    q.push_back(V(3'b111, 'hB2, 3'b111, 'hC1, 1, 3'b001, 'hB1, 2'b11, 1, 0));
    q.push_back(V(3'b111, 'hB2, 3'b111, 'hC1, 1, 3'b010, 0,     2'b00, 1, 0));
    q.push_back(V(3'b111, 'hB2, 3'b111, 'hC2, 1, 3'b001, 'hC1, 2'b11, 1, 1));
    q.push_back(V(3'b111, 'hB2, 3'b111, 'hC2, 1, 3'b100, 0,     2'b00, 1, 1));
    q.push_back(V(3'b000, 0,    3'b111, 'hC2, 1, 3'b001, 'hB2, 2'b11, 2, 1));
    q.push_back(V(3'b000, 0,    3'b111, 'hC2, 1, 3'b010, 0,     2'b00, 2, 1));
    q.push_back(V(3'b000, 0,    3'b000, 0,    1, 3'b001, 'hC2, 2'b11, 2, 2));
    q.push_back(V(3'b000, 0,    3'b000, 0,    1, 3'b000, 0,     2'b00, 2, 2));
    q.push_back(V(3'b110, 'hA1, 3'b000, 0,    1, 3'b000, 0,     2'b00, 2, 2));
    q.push_back(V(3'b110, 'hA1, 3'b000, 0,    1, 3'b100, 0,     2'b00, 2, 2));
    q.push_back(V(3'b100, 'hA2, 3'b000, 0,    1, 3'b101, 'hA1, 2'b10, 2, 2));
    q.push_back(V(3'b101, 'hA3, 3'b000, 0,    1, 3'b101, 'hA2, 2'b00, 2, 2));
    q.push_back(V(3'b000, 0,    3'b000, 0,    1, 3'b001, 'hA3, 2'b01, 3, 2));
    q.push_back(V(3'b000, 0,    3'b000, 0,    1, 3'b000, 0,     2'b00, 3, 2));
    q.push_back(V(3'b000, 0,    3'b110, 'hD1, 1, 3'b000, 0,     2'b00, 3, 2));
    q.push_back(V(3'b000, 0,    3'b110, 'hD1, 1, 3'b010, 0,     2'b00, 3, 2));
    q.push_back(V(3'b000, 0,    3'b100, 'hD2, 1, 3'b011, 'hD1, 2'b10, 3, 2));
    q.push_back(V(3'b000, 0,    3'b100, 'hD3, 0, 3'b001, 'hD2, 2'b00, 3, 2));
    q.push_back(V(3'b000, 0,    3'b100, 'hD3, 0, 3'b001, 'hD2, 2'b00, 3, 2));
    q.push_back(V(3'b000, 0,    3'b100, 'hD3, 0, 3'b001, 'hD2, 2'b00, 3, 2));
    q.push_back(V(3'b000, 0,    3'b100, 'hD3, 1, 3'b011, 'hD2, 2'b00, 3, 2));
    q.push_back(V(3'b000, 0,    3'b101, 'hD4, 1, 3'b011, 'hD3, 2'b00, 3, 2));
    q.push_back(V(3'b000, 0,    3'b000, 0,    1, 3'b001, 'hD4, 2'b01, 3, 3));
    q.push_back(V(3'b000, 0,    3'b000, 0,    1, 3'b000, 0,     2'b00, 3, 3));
    q.push_back(V(3'b000, 0,    3'b110, 'hE1, 1, 3'b000, 0,     2'b00, 3, 3));
    q.push_back(V(3'b111, 'hF1, 3'b110, 'hE1, 1, 3'b010, 0,     2'b00, 3, 3));
    q.push_back(V(3'b111, 'hF1, 3'b100, 'hE2, 1, 3'b011, 'hE1, 2'b10, 3, 3));
    q.push_back(V(3'b111, 'hF1, 3'b101, 'hE3, 1, 3'b011, 'hE2, 2'b00, 3, 3));
    q.push_back(V(3'b111, 'hF1, 3'b000, 0,    1, 3'b001, 'hE3, 2'b01, 3, 4));
    q.push_back(V(3'b111, 'hF1, 3'b000, 0,    1, 3'b100, 0,     2'b00, 3, 4));
    q.push_back(V(3'b000, 0,    3'b000, 0,    1, 3'b001, 'hF1, 2'b11, 4, 4));
    q.push_back(V(3'b000, 0,    3'b000, 0,    1, 3'b000, 0,     2'b00, 4, 4));
    q.push_back(V(3'b100, 'h99, 3'b000, 0,    1, 3'b000, 0,     2'b00, 4, 4));
    q.push_back(V(3'b100, 'h99, 3'b000, 0,    1, 3'b000, 0,     2'b00, 4, 4));
    q.push_back(V(3'b000, 0,    3'b000, 0,    1, 3'b000, 0,     2'b00, 4, 4));
    foreach (q[i]) begin
      @(negedge clk);
      drive(q[i].in0, q[i].d0, q[i].in1, q[i].d1, q[i].sr);
      #1;
      chk($sformatf("row%0d r0", i), c0_if.ready, q[i].rv[2]);
      chk($sformatf("row%0d r1", i), c1_if.ready, q[i].rv[1]);
      chk($sformatf("row%0d valid", i), tx_if.valid, q[i].rv[0]);
      if (q[i].rv[0]) begin
        chk($sformatf("row%0d data", i), tx_if.data, q[i].od);
        chk($sformatf("row%0d head", i), tx_if.head, hd(q[i].od));
        chk($sformatf("row%0d start", i), tx_if.start, q[i].sl[1]);
        chk($sformatf("row%0d last", i), tx_if.last, q[i].sl[0]);
      end
      chk($sformatf("row%0d cnt0", i), cnt0, q[i].c0);
      chk($sformatf("row%0d cnt1", i), cnt1, q[i].c1);
    end
    @(negedge clk);
    {p0_if.valid, p0_if.start, p0_if.last} = 3'b111;
    p0_if.data = 'h10;
    {p1_if.valid, p1_if.start, p1_if.last} = 3'b111;
    p1_if.data = 'h20;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("prio r0", p0_if.ready, 0);
      if (ptx_if.valid) begin
        seen++;
        chk("prio data", ptx_if.data, 'h20);
      end
      @(negedge clk);
    end
    #1;
    chk("prio beats", seen, 4);
    chk("prio cnt1 wrap", pcnt1, 1);
    chk("prio cnt0", pcnt0, 0);
    {p0_if.valid, p1_if.valid} = 2'b00;
    @(negedge clk) drive(3'b110, 'h71, 3'b000, 0, 1);
    @(negedge clk);
    @(negedge clk) drive(3'b100, 'h72, 3'b000, 0, 1);
    @(negedge clk);
    #1;
    chk("mid data", tx_if.data, 'h72);
    rst_n = 1'b0;
    #1;
    chk("arst valid", tx_if.valid, 0);
    chk("arst data", tx_if.data, 0);
    chk("arst head", tx_if.head, 0);
    chk("arst start/last", {tx_if.start, tx_if.last}, 0);
    chk("arst ready", {c0_if.ready, c1_if.ready}, 0);
    chk("arst cnt", cnt0 | cnt1, 0);
    @(negedge clk);
    drive(3'b101, 'h73, 3'b000, 0, 1);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("post-rst r0", c0_if.ready, 0);
      chk("post-rst valid", tx_if.valid, 0);
      chk("post-rst cnt0", cnt0, 0);
      @(negedge clk);
    end
    drive(3'b000, 0, 3'b000, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
